nalu_byte_extractor: RTL and testbench

NALU_BYTE_EXTRACTOR -- requirements
Module: nalu_byte_extractor

---
 rtl/nalu_byte_extractor_pkg.sv | 17 +
 rtl/nalu_byte_extractor_in_buf.sv | 59 +++++
 rtl/nalu_byte_extractor.sv | 169 ++++++++++++++++
 tb/tb_nalu_byte_extractor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nalu_byte_extractor_pkg.sv
// rtl/nalu_byte_extractor_pkg.sv - shared state encodings and byte constants for the NAL byte extractor
package nalu_byte_extractor_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    PAYLOAD = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  localparam logic [7:0] START_CODE_BYTE = 8'h01;
  localparam logic [7:0] EPB_BYTE        = 8'h03;

  function automatic logic [1:0] zero_cnt_inc(input logic [1:0] cnt);
    return (cnt == 2'd2) ? 2'd2 : cnt + 2'd1;
  endfunction

endpackage

// File: rtl/nalu_byte_extractor_in_buf.sv
// rtl/nalu_byte_extractor_in_buf.sv - 2-entry input buffer tracking the 1-cycle upstream read latency
module nalu_in_buf
  import nalu_byte_extractor_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fifo_ready,
  output logic       fifo_read,
  input  logic [7:0] fifo_q,
  input  logic       pop,
  output logic       head_valid,
  output logic [7:0] head_data
);

  logic       run_q, run_d;
  logic       inflight_q, inflight_d;
  logic [1:0] cnt_q, cnt_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [7:0] mem_q [2];
  logic [7:0] mem_d [2];
  logic       pop_ok;

  assign head_valid = (cnt_q != 2'd0);
  assign head_data  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok     = pop && head_valid;
    cnt_d      = cnt_q + {1'b0, inflight_q} - {1'b0, pop_ok};
    // Room is judged after this cycle's pop so a streaming consumer keeps one read in flight every cycle.
    fifo_read  = run_q && fifo_ready && (cnt_d < 2'd2);
    inflight_d = fifo_read;
    run_d      = 1'b1;
    mem_d      = mem_q;
    if (inflight_q) mem_d[wr_ptr_q] = fifo_q;
    wr_ptr_d   = wr_ptr_q ^ inflight_q;
    rd_ptr_d   = rd_ptr_q ^ pop_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      mem_q[0]   <= 8'h00;
      mem_q[1]   <= 8'h00;
    end else begin
      run_q      <= run_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: rtl/nalu_byte_extractor.sv
// rtl/nalu_byte_extractor.sv - strips start codes (and 0x03 emulation-prevention bytes when
// NALU_EPB_REMOVE_EN is defined) from an Annex-B byte stream, emitting NAL payload bytes
module nalu_byte_extractor
  import nalu_byte_extractor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_ready,
  output logic        fifo_read,
  input  logic [7:0]  fifo_q,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic [15:0] epb_count
);

  state_e     state_q, state_d;
  logic [1:0] zero_cnt_q, zero_cnt_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic       first_pend_q, first_pend_d;
  logic [7:0] pend_q, pend_d;
  logic       pend_valid_q, pend_valid_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_first_q, out_first_d;
  logic       head_valid, pop, out_free, emit;
  logic [7:0] head_data, emit_data;

`ifdef NALU_EPB_REMOVE_EN
  logic [15:0] epb_q, epb_d;
  assign epb_count = epb_q;
`else
  assign epb_count = 16'd0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_first = out_first_q;

  nalu_in_buf u_in_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_ready (fifo_ready),
    .fifo_read  (fifo_read),
    .fifo_q     (fifo_q),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  always_comb begin
    state_d      = state_q;
    zero_cnt_d   = zero_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    first_pend_d = first_pend_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_first_d  = out_first_q;
    emit         = 1'b0;
    emit_data    = 8'h00;
`ifdef NALU_EPB_REMOVE_EN
    epb_d        = epb_q;
`endif
    out_free = !out_valid_q || out_ready;
    pop      = (state_q != FLUSH) && head_valid && out_free;
    if (out_ready) begin
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
    end

    case (state_q)
      SEARCH: if (pop) begin
        if (head_data == 8'h00) begin
          zero_cnt_d = zero_cnt_inc(zero_cnt_q);
        end else if (head_data == START_CODE_BYTE && zero_cnt_q == 2'd2) begin
          state_d      = PAYLOAD;
          first_pend_d = 1'b1;
          zero_cnt_d   = 2'd0;
        end else begin
          zero_cnt_d = 2'd0;
        end
      end
      PAYLOAD: if (pop) begin
        if (head_data == 8'h00) begin
          // A third zero means the held zeros were trailing padding, not payload.
          zero_cnt_d = zero_cnt_inc(zero_cnt_q);
          if (zero_cnt_q == 2'd2) state_d = SEARCH;
        end else if (head_data == START_CODE_BYTE && zero_cnt_q == 2'd2) begin
          first_pend_d = 1'b1;
          zero_cnt_d   = 2'd0;
        end
`ifdef NALU_EPB_REMOVE_EN
        else if (head_data == EPB_BYTE && zero_cnt_q == 2'd2) begin
          epb_d        = epb_q + 16'd1;
          flush_cnt_d  = 2'd2;
          pend_valid_d = 1'b0;
          zero_cnt_d   = 2'd0;
          state_d      = FLUSH;
        end
`endif
        else if (zero_cnt_q != 2'd0) begin
          flush_cnt_d  = zero_cnt_q;
          pend_d       = head_data;
          pend_valid_d = 1'b1;
          zero_cnt_d   = 2'd0;
          state_d      = FLUSH;
        end else begin
          emit      = 1'b1;
          emit_data = head_data;
        end
      end
      FLUSH: if (out_free) begin
        if (flush_cnt_q != 2'd0) begin
          emit        = 1'b1;
          emit_data   = 8'h00;
          flush_cnt_d = flush_cnt_q - 2'd1;
          if (flush_cnt_q == 2'd1 && !pend_valid_q) state_d = PAYLOAD;
        end else begin
          emit         = pend_valid_q;
          emit_data    = pend_q;
          pend_valid_d = 1'b0;
          state_d      = PAYLOAD;
        end
      end
      default: state_d = SEARCH;
    endcase

    if (emit) begin
      out_valid_d  = 1'b1;
      out_data_d   = emit_data;
      out_first_d  = first_pend_q;
      first_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      zero_cnt_q   <= 2'd0;
      flush_cnt_q  <= 2'd0;
      first_pend_q <= 1'b0;
      pend_q       <= 8'h00;
      pend_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_first_q  <= 1'b0;
`ifdef NALU_EPB_REMOVE_EN
      epb_q        <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      zero_cnt_q   <= zero_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      first_pend_q <= first_pend_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_first_q  <= out_first_d;
`ifdef NALU_EPB_REMOVE_EN
      epb_q        <= epb_d;
`endif
    end
  end

endmodule

// File: tb/tb_nalu_byte_extractor.sv
// tb/tb_nalu_byte_extractor.sv - scoreboard bench for nalu_byte_extractor (honours NALU_EPB_REMOVE_EN)
module tb_nalu_byte_extractor;

  logic        clk = 1'b0;
  logic        rst_n, fifo_ready, fifo_read, out_valid, out_ready, out_first;
  logic [7:0]  fifo_q, out_data;
  logic [15:0] epb_count;

`ifdef NALU_EPB_REMOVE_EN
  localparam bit EPB_ON = 1'b1;
`else
  localparam bit EPB_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       f;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src[$];
  logic [7:0] stim[$];
  int         errors = 0, checks = 0, cyc = 0, rd_viol = 0;
  int         hs_cnt, first_hs, last_hs, ready_mode, epb_total;
  bit         gap_en, rd_pend, stall_prev;
  logic [7:0] rd_byte, stall_data;
  logic       stall_first;

  nalu_byte_extractor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_ready (fifo_ready),
    .fifo_read  (fifo_read),
    .fifo_q     (fifo_q),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_first  (out_first),
    .epb_count  (epb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add(input logic [255:0] v, input int n);
    for (int i = 0; i < n; i++) stim.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic f);
    exp_q.push_back({d, f});
  endtask

  // Reference behaviour of the extractor applied to stim, starting from a fresh start-code search.
  function automatic int nal_model();
    int zc = 0, epb = 0;
    bit pay = 0, fp = 0;
    logic [7:0] b;
    foreach (stim[i]) begin
      b = stim[i];
      if (b == 8'h00) begin
        if (pay && zc == 2) pay = 0;
        zc = (zc == 2) ? 2 : zc + 1;
      end else if (b == 8'h01 && zc == 2) begin
        pay = 1; fp = 1; zc = 0;
      end else if (!pay) begin
        zc = 0;
      end else begin
        for (int k = 0; k < zc; k++) begin exp_q.push_back({8'h00, fp}); fp = 0; end
        if (b == 8'h03 && zc == 2 && EPB_ON) epb++;
        else begin exp_q.push_back({b, fp}); fp = 0; end
        zc = 0;
      end
    end
    return epb;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rd_pend) begin fifo_q = rd_byte; rd_pend = 0; end
    out_ready  = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    fifo_ready = (src.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    #1;
    if (fifo_read) begin
      if (!fifo_ready) rd_viol++;
      else if (src.size() > 0) begin rd_byte = src.pop_front(); rd_pend = 1; end
    end
    if (stall_prev)
      check("hold_stable", {out_valid, out_data, out_first}, {1'b1, stall_data, stall_first});
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (hs_cnt == 1) first_hs = cyc;
      last_hs = cyc;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL extra_byte: observed out_data=%0h expected no output", out_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("out_byte%0d", hs_cnt), {out_data, out_first}, {e.d, e.f});
      end
    end
    stall_prev  = out_valid && !out_ready;
    stall_data  = out_data;
    stall_first = out_first;
  endtask

  task automatic run_stream(input string tag, input int mode, input bit gaps);
    ready_mode = mode;
    gap_en     = gaps;
    hs_cnt     = 0;
    foreach (stim[i]) src.push_back(stim[i]);
    stim.delete();
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (src.size() == 0 && !rd_pend && exp_q.size() == 0) break;
    end
    repeat (12) tick();
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_read_while_empty"}, rd_viol, 0);
    exp_q.delete();
    src.delete();
  endtask

  initial begin
    rst_n = 1'b0; fifo_ready = 1'b1; out_ready = 1'b1; fifo_q = 8'h00;
    rd_pend = 0; stall_prev = 0; ready_mode = 0; gap_en = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_first", out_first, 0);
    check("rst_out_data", out_data, 0);
    check("rst_epb_count", epb_count, 0);
    check("rst_fifo_read", fifo_read, 0);
    fifo_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    add(64'h00000001_6742001E, 8);
    expect_byte(8'h67, 1); expect_byte(8'h42, 0); expect_byte(8'h00, 0); expect_byte(8'h1E, 0);
    run_stream("basic", 0, 0);

    add(72'h000001_650000_030188, 9);
    expect_byte(8'h65, 1); expect_byte(8'h00, 0); expect_byte(8'h00, 0);
    if (!EPB_ON) expect_byte(8'h03, 0);
    expect_byte(8'h01, 0); expect_byte(8'h88, 0);
    run_stream("epb", 0, 0);
    epb_total = EPB_ON ? 1 : 0;
    check("epb_count_after_epb", epb_count, epb_total);

    add(88'h000001_41AA_000000_01_09F0, 11);
    expect_byte(8'h41, 1); expect_byte(8'hAA, 0); expect_byte(8'h09, 1); expect_byte(8'hF0, 0);
    run_stream("trailing", 0, 0);

    add(24'h000001, 3);
    for (int i = 0; i < 16; i++) begin
      stim.push_back(8'h10 + 8'(i));
      expect_byte(8'h10 + 8'(i), (i == 0));
    end
    run_stream("tput", 0, 0);
    check("tput_count", hs_cnt, 16);
    check("tput_span", last_hs - first_hs, 15);

    add(24'h000001, 3);
    for (int i = 0; i < 64; i++) begin
      int r;
      r = $urandom_range(0, 9);
      stim.push_back(r < 4 ? 8'h00 : r == 4 ? 8'h03 : r == 5 ? 8'h01 : 8'($urandom_range(0, 255)));
    end
    epb_total += nal_model();
    run_stream("random", 1, 1);
    check("epb_count_after_random", epb_count, epb_total & 16'hFFFF);

    add(48'h000001_250000, 6);
    expect_byte(8'h25, 1);
    run_stream("pre_reset", 0, 0);
    @(negedge clk);
    rst_n = 1'b0; fifo_ready = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_first", out_first, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_epb_count", epb_count, 0);
    check("mid_rst_fifo_read", fifo_read, 0);
    rd_pend = 0; stall_prev = 0; fifo_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    add(32'h00000121, 4);
    expect_byte(8'h21, 1);
    run_stream("post_reset", 0, 0);
    check("epb_count_post_reset", epb_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
